// File: rtl/iir_tc_sequencer.sv
// Measurement sequencer: programs the IIR shift coefficient, waits flush + settle, averages filter output.
// Latency: PIPE_LAT + 2^(k+SETTLE_TC_LOG2) + 2^AVG_LOG2 cycles from accepted start to o_result_valid.
// Backpressure: result held stable in HOLD until i_result_ready; new starts ignored until back in IDLE.
module iir_tc_sequencer #(
  parameter int PIPE_LAT       = 3,
  parameter int SETTLE_TC_LOG2 = 3,
  parameter int AVG_LOG2       = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [3:0]         i_tc_code,
  input  logic               i_abort,
  output logic               o_busy,
  output logic               o_tc_err,
  output logic [3:0]         o_coefficient,
  input  logic signed [35:0] i_filt_data,
  output logic signed [35:0] o_result,
  output logic               o_result_valid,
  input  logic               i_result_ready
);

  localparam int ACC_W = 36 + AVG_LOG2;
  localparam int CNT_W = 26;
  // PIPE_LAT must be at least 1 so the flush phase has a terminal count.
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(PIPE_LAT - 1);
  localparam logic [CNT_W-1:0] ACCUM_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FLUSH  = 3'd1,
    SETTLE = 3'd2,
    ACCUM  = 3'd3,
    HOLD   = 3'd4
  } state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic signed [ACC_W-1:0] acc_q;
  logic                    busy_q;
  logic                    err_q;
  logic [3:0]              coef_q;
  logic signed [35:0]      result_q;
  logic                    valid_q;

  // Invalid codes fall back to code 10 (k=18) and raise the error flag.
  logic       code_bad_d;
  logic [3:0] code_eff_d;
  assign code_bad_d = (i_tc_code == 4'd0) || (i_tc_code > 4'd12);
  assign code_eff_d = code_bad_d ? 4'd10 : i_tc_code;

  // Shift k of the filter, derived from the latched (always valid) coefficient code.
  logic [4:0] shift_k;
  always_comb begin
    shift_k = 5'd18;
    case (coef_q)
      4'd1:    shift_k = 5'd3;
      4'd2:    shift_k = 5'd5;
      4'd3:    shift_k = 5'd7;
      4'd4:    shift_k = 5'd8;
      4'd5:    shift_k = 5'd10;
      4'd6:    shift_k = 5'd12;
      4'd7:    shift_k = 5'd13;
      4'd8:    shift_k = 5'd15;
      4'd9:    shift_k = 5'd17;
      4'd10:   shift_k = 5'd18;
      4'd11:   shift_k = 5'd20;
      4'd12:   shift_k = 5'd22;
      default: shift_k = 5'd18;
    endcase
  end

  // Settle length is 2^(k+SETTLE_TC_LOG2); the counter runs 0..S-1.
  logic [5:0]       settle_log2;
  logic [CNT_W-1:0] settle_last;
  assign settle_log2 = 6'(shift_k) + 6'(SETTLE_TC_LOG2);
  assign settle_last = (CNT_W'(1) << settle_log2) - CNT_W'(1);

  // Running sum including the sample presented this cycle (sign-extended).
  logic signed [ACC_W-1:0] acc_sum_d;
  assign acc_sum_d = acc_q + ACC_W'(i_filt_data);

  // Sequencer FSM with registered outputs; abort outranks every other request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      coef_q   <= 4'b1010;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else if (i_abort && (state_q != IDLE)) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start && !i_abort) begin
            coef_q  <= code_eff_d;
            err_q   <= code_bad_d;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            acc_q   <= '0;
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (cnt_q == FLUSH_LAST) begin
            cnt_q   <= '0;
            state_q <= SETTLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        SETTLE: begin
          if (cnt_q == settle_last) begin
            cnt_q   <= '0;
            state_q <= ACCUM;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ACCUM: begin
          acc_q <= acc_sum_d;
          if (cnt_q == ACCUM_LAST) begin
            cnt_q    <= '0;
            // Arithmetic shift gives floor rounding; upper bits dropped, no saturation.
            result_q <= 36'(acc_sum_d >>> AVG_LOG2);
            valid_q  <= 1'b1;
            state_q  <= HOLD;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HOLD: begin
          if (i_result_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy         = busy_q;
  assign o_tc_err       = err_q;
  assign o_coefficient  = coef_q;
  assign o_result       = result_q;
  assign o_result_valid = valid_q;

endmodule

// File: tb/tb_iir_tc_sequencer.sv
// Bench for iir_tc_sequencer: directed steps plus randomized measurements against a latency/average model.
// Inputs driven and outputs sampled on the falling clock edge.
// Each measurement predicts latency and averaged result from the code table and the samples it applied.
module tb_iir_tc_sequencer;

  localparam int PIPE_LAT       = 3;
  localparam int SETTLE_TC_LOG2 = 3;
  localparam int AVG_LOG2       = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [3:0]         tc_code;
  logic               abort;
  logic               busy;
  logic               tc_err;
  logic [3:0]         coef;
  logic signed [35:0] filt;
  logic signed [35:0] result;
  logic               result_valid;
  logic               ready;

  int checks = 0;
  int errors = 0;

  // Shift k for each code; index 0 and 13..15 hold the fallback shift of code 10.
  int shift_tab [0:15] = '{18, 3, 5, 7, 8, 10, 12, 13, 15, 17, 18, 20, 22, 18, 18, 18};

  longint dat [0:2199];

  iir_tc_sequencer #(
    .PIPE_LAT(PIPE_LAT),
    .SETTLE_TC_LOG2(SETTLE_TC_LOG2),
    .AVG_LOG2(AVG_LOG2)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .i_tc_code(tc_code),
    .i_abort(abort),
    .o_busy(busy),
    .o_tc_err(tc_err),
    .o_coefficient(coef),
    .i_filt_data(filt),
    .o_result(result),
    .o_result_valid(result_valid),
    .i_result_ready(ready)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint rnd36();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return longint'($signed(r[35:0]));
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, tc_err, 0);
    chk({tag, "_valid"}, result_valid, 0);
    chk({tag, "_coef"}, coef, 10);
    chk({tag, "_result"}, result, 0);
  endtask

  // One full measurement. Called and returns just after a falling edge.
  // mode 0: constant c0 every cycle; mode 1: c0..c3 in the averaged window, random elsewhere; mode 2: random.
  task automatic run_meas(input int code, input int mode, input longint c0, input longint c1,
                          input longint c2, input longint c3, input int ready_early, input int hold_len);
    int eff, k, lat, c, win_lo;
    bit bad, got;
    longint v, sum, d, q;
    logic signed [35:0] held;
    bad    = (code == 0) || (code > 12);
    eff    = bad ? 10 : code;
    k      = shift_tab[eff];
    lat    = PIPE_LAT + (1 << (k + SETTLE_TC_LOG2)) + (1 << AVG_LOG2);
    win_lo = lat - (1 << AVG_LOG2) + 1;
    for (int i = 0; i < 2200; i++) dat[i] = 0;

    start   = 1'b1;
    tc_code = 4'(code);
    ready   = ready_early[0];
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_coef", coef, eff);
    chk("start_err", tc_err, bad);

    c = 0;
    got = 1'b0;
    while (!got && c < lat + 20) begin
      if (mode == 0) v = c0;
      else if (mode == 1 && (c + 1) >= win_lo && (c + 1) <= lat) begin
        case (c + 1 - win_lo)
          0: v = c0;
          1: v = c1;
          2: v = c2;
          default: v = c3;
        endcase
      end else v = rnd36();
      filt = 36'(v);
      if (c + 1 < 2200) dat[c + 1] = longint'(filt);
      @(negedge clk);
      c++;
      if (result_valid === 1'b1) got = 1'b1;
    end
    chk("latency", c, lat);
    if (!got) return;

    sum = 0;
    for (int n = win_lo; n <= lat; n++) sum += dat[n];
    d = longint'(1) << AVG_LOG2;
    q = sum / d;
    if ((sum % d) != 0 && sum < 0) q = q - 1;
    chk("result", result, q);
    held = result;

    if (ready_early != 0) begin
      @(negedge clk);
      chk("valid_one_cycle", result_valid, 0);
      chk("busy_after_xfer", busy, 0);
      ready = 1'b0;
    end else begin
      for (int h = 0; h < hold_len; h++) begin
        start   = h[0];
        tc_code = 4'($urandom_range(1, 12));
        filt    = 36'(rnd36());
        @(negedge clk);
        chk("hold_valid", result_valid, 1);
        chk("hold_result", result, held);
        chk("hold_busy", busy, 1);
        chk("hold_coef", coef, eff);
      end
      start   = 1'b1;
      tc_code = 4'($urandom_range(1, 12));
      ready   = 1'b1;
      @(negedge clk);
      chk("xfer_valid", result_valid, 0);
      chk("xfer_busy", busy, 0);
      chk("xfer_coef", coef, eff);
      chk("xfer_result", result, held);
      start = 1'b0;
      ready = 1'b0;
      @(negedge clk);
      chk("no_queued_start", busy, 0);
    end
  endtask

  initial begin
    int nv;
    rst_n   = 1'b0;
    start   = 1'b0;
    tc_code = 4'd0;
    abort   = 1'b0;
    filt    = '0;
    ready   = 1'b0;
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Code 1, constant input, ready held high throughout.
    run_meas(1, 0, 1000, 0, 0, 0, 1, 0);
    // Averaging with floor rounding, positive and negative.
    run_meas(1, 1, 100, 200, 300, 401, 1, 0);
    run_meas(1, 1, -5, -5, -5, -6, 1, 0);

    // Invalid code: fallback coefficient and error flag, then abort (full settle is too long).
    start   = 1'b1;
    tc_code = 4'd14;
    @(negedge clk);
    start = 1'b0;
    chk("bad_coef", coef, 10);
    chk("bad_err", tc_err, 1);
    chk("bad_busy", busy, 1);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("bad_abort_busy", busy, 0);
    chk("bad_err_holds", tc_err, 1);
    chk("bad_coef_holds", coef, 10);
    // Next accepted start with a valid code clears the flag (checked inside).
    run_meas(3, 2, 0, 0, 0, 0, 0, 3);

    // Abort during settle with code 2, then a clean restart.
    start   = 1'b1;
    tc_code = 4'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy_after", busy, 0);
    chk("abort_coef", coef, 2);
    nv = 0;
    repeat (300) begin
      @(negedge clk);
      if (result_valid === 1'b1) nv++;
    end
    chk("abort_no_valid", nv, 0);
    run_meas(2, 2, 0, 0, 0, 0, 1, 0);

    // Backpressure: ready low for 10 cycles with start pulses.
    run_meas(1, 2, 0, 0, 0, 0, 0, 10);

    // Asynchronous reset during settle.
    start   = 1'b1;
    tc_code = 4'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_meas(1, 2, 0, 0, 0, 0, 1, 0);

    // Randomized measurements.
    for (int i = 0; i < 5; i++) begin
      run_meas(int'($urandom_range(1, 4)), 2, 0, 0, 0, 0,
               int'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iir_tc_sequencer.md
# iir_tc_sequencer

Measurement sequencer for the IIR shift low-pass filter stage of the impedance analyzer. It accepts a start request with a time-constant code and drives the filter's coefficient input. It waits for the filter pipeline to flush and for the output to settle to a programmable number of time constants. It then averages 2^AVG_LOG2 filter outputs and hands the result to the downstream consumer with a valid/ready handshake.

## Interface
- PIPE_LAT, 3: cycles from a coefficient change until the filter output reflects it.
- SETTLE_TC_LOG2, 3: settle wait is 2^SETTLE_TC_LOG2 filter time constants.
- AVG_LOG2, 2: number of averaged samples is 2^AVG_LOG2 (range 0..4).
- i_clk  in  1  sole clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  measurement request; sampled only in IDLE.
- i_tc_code  in  4  time-constant code, sampled with i_start.
- i_abort  in  1  cancel the measurement from any state.
- o_busy  out  1  high in every state except IDLE.
- o_tc_err  out  1  last accepted code was invalid (0 or 13..15).
- o_coefficient  out  4  to filter coefficient input.
- i_filt_data  in  36 signed  filter output.
- o_result  out  36 signed  averaged result.
- o_result_valid  out  1  result available.
- i_result_ready  in  1  consumer accepts the result.

## Operation
- Code-to-shift table, shift k:
  - codes 1..6 → 3, 5, 7, 8, 10, 12
  - codes 7..12 → 13, 15, 17, 18, 20, 22
- Invalid code: the block substitutes code 10 (k=18) and sets o_tc_err. The flag holds until the next accepted start.
- Settle count S = 2^(k+SETTLE_TC_LOG2) cycles. The counter is 26 bits wide (max 2^25 at defaults).
- FSM states: IDLE, FLUSH, SETTLE, ACCUM, HOLD.
  - IDLE: on i_start, latch the effective code into o_coefficient, set o_busy, clear the counter, go to FLUSH.
  - FLUSH: count PIPE_LAT cycles, then go to SETTLE.
  - SETTLE: count S cycles, then go to ACCUM.
  - ACCUM: add sign-extended i_filt_data into an accumulator of width 36+AVG_LOG2 every cycle for 2^AVG_LOG2 cycles. The accumulator clears on FLUSH entry. Go to HOLD.
  - HOLD: o_result = accumulator >>> AVG_LOG2, with arithmetic shift, floor rounding, no saturation. o_result_valid=1 and o_result stays stable until i_result_ready=1, then go to IDLE.
- i_abort in any non-IDLE state: go to IDLE on the next edge and deassert o_busy and o_result_valid. o_coefficient and o_result keep their values. i_abort has priority over i_start and i_result_ready.
- i_start outside IDLE is ignored, with no queuing. That includes HOLD and the cycle that leaves HOLD.
- o_coefficient changes only on an accepted start, so the filter state carries over between measurements.

## Timing
- Reset values:
  - state IDLE; o_busy=0, o_tc_err=0, o_result_valid=0.
  - o_coefficient=4'b1010, o_result=0, counters and accumulator 0.
- All outputs are registered. A reset assertion mid-measurement returns to the reset values immediately, with no result.
- Define E0 as the edge that samples i_start=1 in IDLE:
  - o_busy and o_coefficient update after E0.
  - FLUSH occupies E0+1..E0+PIPE_LAT.
  - SETTLE occupies the next S edges.
  - ACCUM samples i_filt_data on the next 2^AVG_LOG2 edges.
  - o_result_valid rises after edge E0+PIPE_LAT+S+2^AVG_LOG2.
- Handshake: the transfer occurs on the edge where o_result_valid and i_result_ready are both 1. o_result_valid and o_busy drop after that edge. i_start is accepted no earlier than the following edge.
- i_result_ready high before valid has no effect.
- Total latency: PIPE_LAT + S + 2^AVG_LOG2 cycles from E0 to valid.

## Test plan
- Code 1, defaults, i_filt_data constant 1000, ready held 1 → o_coefficient=1 after E0; valid after E0+71 for exactly 1 cycle; o_result=1000.
- Code 1, ACCUM inputs 100, 200, 300, 401 → o_result=250. Inputs -5, -5, -5, -6 → o_result=-6.
- Code 14 → o_coefficient=10, o_tc_err=1, valid at E0+2^21+7. A following start with code 3 clears o_tc_err.
- i_abort at E0+20 with code 2 → o_busy=0 after E0+21; no valid. A restart with code 2 gives valid 263 cycles after its new E0.
- HOLD with ready low for 10 cycles while i_start pulses → o_result stable, start ignored. Raising ready → valid and o_busy drop on the next edge; o_coefficient unchanged.
- Reset asserted during SETTLE → all outputs return to reset values asynchronously; o_coefficient=10; the next start proceeds normally.
